pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter PWM_COUNTER_WIDTH, default 8, SHALL set the width of all measurement counters and outputs (W below).
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 a_rst_n_i  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 enable_i  input  1  SHALL gate measurement; low = block idle.
REQ-005 channel_i  input  1  SHALL be the PWM waveform under measurement, asynchronous to clk_i.
REQ-006 period_o  output  W  SHALL hold the last published period, in clk_i cycles between consecutive rising edges.
REQ-007 high_o  output  W  SHALL hold the last published high time, in clk_i cycles, within that period.
REQ-008 valid_o  output  1  SHALL pulse high for exactly one cycle when period_o/high_o update.
REQ-009 timeout_o  output  1  SHALL pulse with valid_o when the published result is a saturated (timeout) measurement.

Function
REQ-010 channel_i SHALL pass through a 2-flop synchronizer; a third flop SHALL hold the previous synchronized level for edge detection.
REQ-011 A rising edge (rise) SHALL be defined as synchronized level 1 with previous level 0; detection latency from channel_i is 3 cycles.
REQ-012 FSM states SHALL be IDLE, ARM, MEASURE.
REQ-013 IDLE: enable_i low forces IDLE from any state within one cycle; counters cleared; period_o/high_o hold their values.
REQ-014 IDLE -> ARM when enable_i is high.
REQ-015 ARM: no counting; rise -> MEASURE, period_cnt=1, high_cnt=1, no publish (partial first period discarded).
REQ-016 MEASURE: each cycle without rise, period_cnt += 1, and high_cnt += 1 if the synchronized level is 1.
REQ-017 MEASURE with rise: period_o <= period_cnt, high_o <= high_cnt, valid_o=1 next cycle, counters restart at 1, stay in MEASURE.
REQ-018 MEASURE when period_cnt equals 2^W-1 and no rise: publish period_o=2^W-1, high_o=high_cnt, valid_o=1, timeout_o=1, go to ARM.
REQ-019 Rise coinciding with saturation SHALL be treated as a normal rise (REQ-017), timeout_o=0.
REQ-020 high_cnt SHALL never exceed period_cnt; neither counter SHALL wrap.
REQ-021 enable_i falling in the same cycle as a rise SHALL take priority: no publish, go to IDLE.
REQ-022 valid_o and timeout_o SHALL be registered; no combinational path from channel_i to any output.

Reset
REQ-023 On a_rst_n_i low, asynchronously: state=IDLE, synchronizer flops=0, counters=0, period_o=0, high_o=0, valid_o=0, timeout_o=0.
REQ-024 Reset mid-measurement SHALL discard the partial period; the first post-reset rise only arms (REQ-015).
REQ-025 Reset deassertion SHALL be used as-is; release synchronization is the integrator's responsibility.

Structure
REQ-026 The FSM state enum and the default counter width constant SHALL live in a shared package pwm_pkg, shared with the PWM generator.
REQ-027 The 2-flop synchronizer SHALL be a separate sub-module sync_2ff (1-bit, async active-low reset), instantiated once.
REQ-028 Edge detection, FSM, counters and output registers SHALL be in pwm_capture.

Verification
REQ-029 W=8, enable=1, channel_i repeating 3 cycles high / 5 low -> from the second rise on, valid_o every 8 cycles with period_o=8, high_o=3, timeout_o=0.
REQ-030 W=8, channel_i one rise then held high -> valid_o with timeout_o=1, period_o=255, high_o=255; FSM back in ARM; a later rise does not publish.
REQ-031 W=8, channel_i one rise, high 10 cycles, then held low -> timeout publish with period_o=255, high_o=10.
REQ-032 Steady 50/50 waveform at period 20, enable_i deasserted mid-period for 4 cycles then reasserted -> no valid_o during IDLE or on the first subsequent rise; next publish period_o=20, high_o=10; outputs hold their values while idle.
REQ-033 a_rst_n_i asserted mid-period with no clock edge -> all outputs 0 immediately; after release, first publish occurs on the second rise with correct values.
REQ-034 Rise coincident with period_cnt=255 -> period_o=255, timeout_o=0, FSM remains in MEASURE.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg
// Definitions shared by the PWM capture block and the PWM generator.
//   PWM_COUNTER_WIDTH_DEFAULT : default width of the PWM measurement/period counters
//   pwm_state_e               : FSM states (IDLE, ARM, MEASURE)
//   pwm_cnt_max()             : saturation value of a counter of a given width
package pwm_pkg;

  localparam int unsigned PWM_COUNTER_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    PWM_IDLE    = 2'd0,
    PWM_ARM     = 2'd1,
    PWM_MEASURE = 2'd2
  } pwm_state_e;

  // All-ones value of a counter that is 'width' bits wide, returned in 32 bits
  function automatic logic [31:0] pwm_cnt_max(input int unsigned width);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(width)) begin
        result[i] = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit.
//   clk_i     : destination clock
//   a_rst_n_i : asynchronous active-low reset, clears both flops
//   d_i       : asynchronous input
//   q_o       : input synchronized to clk_i (two cycles of latency)
module sync_2ff (
  input  logic clk_i,
  input  logic a_rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; the second gives it a full cycle to settle
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture
// Measures period and high time of an asynchronous PWM waveform in clk_i cycles.
//   clk_i     : single clock, all state updates on its rising edge
//   a_rst_n_i : asynchronous active-low reset
//   enable_i  : high = measure, low = idle (counters cleared, results held)
//   channel_i : PWM waveform, asynchronous to clk_i
//   period_o  : last published period (cycles between consecutive rising edges)
//   high_o    : last published high time within that period
//   valid_o   : one-cycle pulse when period_o/high_o update
//   timeout_o : pulses with valid_o when the result is a saturated measurement
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_COUNTER_WIDTH = PWM_COUNTER_WIDTH_DEFAULT
) (
  input  logic                         clk_i,
  input  logic                         a_rst_n_i,
  input  logic                         enable_i,
  input  logic                         channel_i,
  output logic [PWM_COUNTER_WIDTH-1:0] period_o,
  output logic [PWM_COUNTER_WIDTH-1:0] high_o,
  output logic                         valid_o,
  output logic                         timeout_o
);

  localparam int unsigned W = PWM_COUNTER_WIDTH;
  localparam logic [31:0] CntMax32 = pwm_cnt_max(W);
  localparam logic [W-1:0] CntMax = CntMax32[W-1:0];
  localparam logic [W-1:0] CntOne = W'(1);

  pwm_state_e state_q, state_d;

  logic [W-1:0] period_cnt_q, period_cnt_d;
  logic [W-1:0] high_cnt_q, high_cnt_d;
  logic [W-1:0] period_q, period_d;
  logic [W-1:0] high_q, high_d;
  logic         valid_q, valid_d;
  logic         timeout_q, timeout_d;

  logic level_sync;
  logic level_prev_q;
  logic rise;

  sync_2ff u_sync (
    .clk_i     (clk_i),
    .a_rst_n_i (a_rst_n_i),
    .d_i       (channel_i),
    .q_o       (level_sync)
  );

  // Third flop keeps the previous synchronized level for edge detection
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      level_prev_q <= 1'b0;
    end else begin
      level_prev_q <= level_sync;
    end
  end

  assign rise = level_sync & ~level_prev_q;

  // Next-state logic. enable_i low wins over everything, including a rise in
  // the same cycle. The counter restart value is 1 because the rise cycle
  // itself belongs to the new period and is a high cycle. high_cnt only
  // advances together with period_cnt, so it can never overtake it, and the
  // saturation check stops period_cnt before it could wrap.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    period_d     = period_q;
    high_d       = high_q;
    valid_d      = 1'b0;
    timeout_d    = 1'b0;

    if (!enable_i) begin
      state_d      = PWM_IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
    end else begin
      case (state_q)
        PWM_IDLE: begin
          state_d      = PWM_ARM;
          period_cnt_d = '0;
          high_cnt_d   = '0;
        end

        PWM_ARM: begin
          // The first rise only aligns us to the waveform; the partial
          // period before it is discarded
          if (rise) begin
            state_d      = PWM_MEASURE;
            period_cnt_d = CntOne;
            high_cnt_d   = CntOne;
          end else begin
            period_cnt_d = '0;
            high_cnt_d   = '0;
          end
        end

        PWM_MEASURE: begin
          if (rise) begin
            // A rise exactly at saturation is still a normal measurement
            period_d     = period_cnt_q;
            high_d       = high_cnt_q;
            valid_d      = 1'b1;
            period_cnt_d = CntOne;
            high_cnt_d   = CntOne;
          end else if (period_cnt_q == CntMax) begin
            period_d     = CntMax;
            high_d       = high_cnt_q;
            valid_d      = 1'b1;
            timeout_d    = 1'b1;
            state_d      = PWM_ARM;
            period_cnt_d = '0;
            high_cnt_d   = '0;
          end else begin
            period_cnt_d = period_cnt_q + CntOne;
            if (level_sync) begin
              high_cnt_d = high_cnt_q + CntOne;
            end
          end
        end

        default: begin
          state_d      = PWM_IDLE;
          period_cnt_d = '0;
          high_cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state_q      <= PWM_IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign period_o  = period_q;
  assign high_o    = high_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
// Self-checking bench for pwm_capture (W=8). Streams of channel samples are
// driven one per clock; a reference model derives the expected publishes from
// the list of rising-edge positions in the stream.
module tb_pwm_capture;

  localparam int MAX = 255;

  typedef struct packed {
    logic [7:0] period;
    logic [7:0] high;
    logic       timeout;
  } pub_t;

  logic       clk;
  logic       aRstN;
  logic       enable;
  logic       channel;
  logic [7:0] periodOut;
  logic [7:0] highOut;
  logic       validOut;
  logic       timeoutOut;

  int checkCount = 0;
  int passCount  = 0;
  int strayTimeout = 0;

  bit   stim[$];
  pub_t expQ[$];
  pub_t obsQ[$];

  pwm_capture #(.PWM_COUNTER_WIDTH(8)) dut (
    .clk_i     (clk),
    .a_rst_n_i (aRstN),
    .enable_i  (enable),
    .channel_i (channel),
    .period_o  (periodOut),
    .high_o    (highOut),
    .valid_o   (validOut),
    .timeout_o (timeoutOut)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every publish seen by the outside world
  always @(negedge clk) begin
    if (validOut) obsQ.push_back('{periodOut, highOut, timeoutOut});
    if (timeoutOut && !validOut) strayTimeout++;
  end

  // Number of high samples in stim[a .. a+len-1]
  function automatic int highSum(input int a, input int len);
    int s = 0;
    for (int i = a; i < a + len; i++) s += int'(stim[i]);
    return s;
  endfunction

  // Expected publishes from the edge list: the first edge only arms; every
  // gap of at most MAX cycles publishes normally, a longer gap times out at
  // MAX cycles and its closing edge re-arms.
  task automatic computeModel();
    int edgeList[$];
    int armStart;
    int gap;
    expQ.delete();
    for (int t = 0; t < stim.size(); t++) begin
      if (stim[t] && (t == 0 || !stim[t-1])) edgeList.push_back(t);
    end
    if (edgeList.size() == 0) return;
    armStart = edgeList[0];
    for (int k = 1; k < edgeList.size(); k++) begin
      gap = edgeList[k] - armStart;
      if (gap <= MAX) expQ.push_back('{8'(gap), 8'(highSum(armStart, gap)), 1'b0});
      else            expQ.push_back('{8'(MAX), 8'(highSum(armStart, MAX)), 1'b1});
      armStart = edgeList[k];
    end
    if (stim.size() - armStart > MAX)
      expQ.push_back('{8'(MAX), 8'(highSum(armStart, MAX)), 1'b1});
  endtask

  task automatic pushLevel(input bit lvl, input int n);
    for (int i = 0; i < n; i++) stim.push_back(lvl);
  endtask

  // Pass through IDLE, then drive stim one sample per clock and let it drain
  task automatic playStream();
    @(negedge clk);
    enable  = 1'b0;
    channel = 1'b0;
    repeat (3) @(negedge clk);
    obsQ.delete();
    enable = 1'b1;
    computeModel();
    foreach (stim[i]) begin
      channel = stim[i];
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    aRstN   = 1'b0;
    enable  = 1'b0;
    channel = 1'b0;
    repeat (3) @(negedge clk);
    checkCount++;
    if (periodOut !== 8'd0) $display("[TB] FAIL reset_period got %0d want 0", periodOut);
    else passCount++;
    checkCount++;
    if (highOut !== 8'd0) $display("[TB] FAIL reset_high got %0d want 0", highOut);
    else passCount++;
    checkCount++;
    if (validOut !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", validOut);
    else passCount++;
    checkCount++;
    if (timeoutOut !== 1'b0) $display("[TB] FAIL reset_timeout got %b want 0", timeoutOut);
    else passCount++;
    aRstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_steady();
    stim.delete();
    pushLevel(1'b0, 5);
    for (int p = 0; p < 10; p++) begin
      pushLevel(1'b1, 3);
      pushLevel(1'b0, 5);
    end
    pushLevel(1'b0, 300);
    playStream();
    checkCount++;
    if (obsQ.size() != expQ.size() || expQ.size() != 10)
      $display("[TB] FAIL steady_count got %0d want %0d (model %0d)", obsQ.size(), 10, expQ.size());
    else passCount++;
    for (int i = 0; i < 9 && i < obsQ.size(); i++) begin
      checkCount++;
      if (obsQ[i] !== '{8'd8, 8'd3, 1'b0})
        $display("[TB] FAIL steady_pub%0d got p=%0d h=%0d t=%b want p=8 h=3 t=0",
                 i, obsQ[i].period, obsQ[i].high, obsQ[i].timeout);
      else passCount++;
    end
  endtask

  task automatic test_held_high();
    stim.delete();
    pushLevel(1'b0, 5);
    pushLevel(1'b1, 300);
    pushLevel(1'b0, 20);
    pushLevel(1'b1, 5);
    pushLevel(1'b0, 300);
    playStream();
    checkCount++;
    if (obsQ.size() != 2 || expQ.size() != 2)
      $display("[TB] FAIL held_high_count got %0d want 2 (model %0d)", obsQ.size(), expQ.size());
    else passCount++;
    if (obsQ.size() >= 1) begin
      checkCount++;
      if (obsQ[0] !== '{8'd255, 8'd255, 1'b1})
        $display("[TB] FAIL held_high_timeout got p=%0d h=%0d t=%b want p=255 h=255 t=1",
                 obsQ[0].period, obsQ[0].high, obsQ[0].timeout);
      else passCount++;
    end
    if (obsQ.size() >= 2) begin
      checkCount++;
      if (obsQ[1] !== expQ[1])
        $display("[TB] FAIL held_high_rearm got p=%0d h=%0d t=%b want p=%0d h=%0d t=%b",
                 obsQ[1].period, obsQ[1].high, obsQ[1].timeout,
                 expQ[1].period, expQ[1].high, expQ[1].timeout);
      else passCount++;
    end
  endtask

  task automatic test_high10();
    stim.delete();
    pushLevel(1'b0, 5);
    pushLevel(1'b1, 10);
    pushLevel(1'b0, 300);
    playStream();
    checkCount++;
    if (obsQ.size() != 1)
      $display("[TB] FAIL high10_count got %0d want 1", obsQ.size());
    else passCount++;
    if (obsQ.size() >= 1) begin
      checkCount++;
      if (obsQ[0] !== '{8'd255, 8'd10, 1'b1})
        $display("[TB] FAIL high10_pub got p=%0d h=%0d t=%b want p=255 h=10 t=1",
                 obsQ[0].period, obsQ[0].high, obsQ[0].timeout);
      else passCount++;
    end
  endtask

  task automatic test_coincident();
    stim.delete();
    pushLevel(1'b0, 5);
    pushLevel(1'b1, 10);
    pushLevel(1'b0, 245);
    pushLevel(1'b1, 3);
    pushLevel(1'b0, 5);
    pushLevel(1'b1, 3);
    pushLevel(1'b0, 300);
    playStream();
    checkCount++;
    if (obsQ.size() != 3)
      $display("[TB] FAIL coincident_count got %0d want 3", obsQ.size());
    else passCount++;
    if (obsQ.size() >= 2) begin
      checkCount++;
      if (obsQ[0] !== '{8'd255, 8'd10, 1'b0})
        $display("[TB] FAIL coincident_pub got p=%0d h=%0d t=%b want p=255 h=10 t=0",
                 obsQ[0].period, obsQ[0].high, obsQ[0].timeout);
      else passCount++;
      checkCount++;
      if (obsQ[1] !== '{8'd8, 8'd3, 1'b0})
        $display("[TB] FAIL coincident_still_measuring got p=%0d h=%0d t=%b want p=8 h=3 t=0",
                 obsQ[1].period, obsQ[1].high, obsQ[1].timeout);
      else passCount++;
    end
  endtask

  task automatic test_enable_gap();
    int validsEarly = 0;
    int validsTotal = 0;
    bit lvl;
    @(negedge clk);
    enable  = 1'b0;
    channel = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    for (int t = 0; t <= 180; t++) begin
      lvl = (t >= 5) && (((t - 5) % 20) < 10);
      if (t == 118) begin
        checkCount++;
        if (periodOut !== 8'd20 || highOut !== 8'd10)
          $display("[TB] FAIL enable_steady got p=%0d h=%0d want p=20 h=10", periodOut, highOut);
        else passCount++;
      end
      if (t == 119) enable = 1'b0;
      if (t == 123) enable = 1'b1;
      if (t >= 119 && t <= 124) begin
        checkCount++;
        if (validOut !== 1'b0 || periodOut !== 8'd20 || highOut !== 8'd10)
          $display("[TB] FAIL enable_idle_hold t=%0d got v=%b p=%0d h=%0d want v=0 p=20 h=10",
                   t, validOut, periodOut, highOut);
        else passCount++;
      end
      if (t >= 123 && validOut) begin
        validsTotal++;
        if (t < 145) validsEarly++;
        checkCount++;
        if (periodOut !== 8'd20 || highOut !== 8'd10 || timeoutOut !== 1'b0)
          $display("[TB] FAIL enable_resume_pub got p=%0d h=%0d t=%b want p=20 h=10 t=0",
                   periodOut, highOut, timeoutOut);
        else passCount++;
      end
      channel = lvl;
      @(negedge clk);
    end
    checkCount++;
    if (validsEarly != 0)
      $display("[TB] FAIL enable_first_rise_arms got %0d publishes want 0", validsEarly);
    else passCount++;
    checkCount++;
    if (validsTotal != 2)
      $display("[TB] FAIL enable_resume_count got %0d want 2", validsTotal);
    else passCount++;
  endtask

  task automatic test_async_reset();
    int valids = 0;
    bit lvl;
    @(negedge clk);
    enable  = 1'b0;
    channel = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    for (int t = 0; t <= 60; t++) begin
      lvl = (t >= 5) && (((t - 5) % 8) < 3);
      if (t == 42) begin
        checkCount++;
        if (periodOut !== 8'd8)
          $display("[TB] FAIL areset_before got p=%0d want 8", periodOut);
        else passCount++;
        #2 aRstN = 1'b0;
        #1;
        checkCount++;
        if (periodOut !== 8'd0 || highOut !== 8'd0 || validOut !== 1'b0 || timeoutOut !== 1'b0)
          $display("[TB] FAIL areset_immediate got p=%0d h=%0d v=%b t=%b want all 0",
                   periodOut, highOut, validOut, timeoutOut);
        else passCount++;
      end
      if (t == 43) aRstN = 1'b1;
      if (t == 52) begin
        checkCount++;
        if (periodOut !== 8'd0 || valids != 0)
          $display("[TB] FAIL areset_first_rise_arms got p=%0d publishes=%0d want p=0 publishes=0",
                   periodOut, valids);
        else passCount++;
      end
      if (t > 43 && validOut) begin
        valids++;
        checkCount++;
        if (periodOut !== 8'd8 || highOut !== 8'd3 || timeoutOut !== 1'b0)
          $display("[TB] FAIL areset_pub got p=%0d h=%0d t=%b want p=8 h=3 t=0",
                   periodOut, highOut, timeoutOut);
        else passCount++;
      end
      channel = lvl;
      @(negedge clk);
    end
    checkCount++;
    if (valids != 1)
      $display("[TB] FAIL areset_count got %0d want 1", valids);
    else passCount++;
  endtask

  task automatic test_random();
    int hi;
    int lo;
    for (int round = 0; round < 3; round++) begin
      stim.delete();
      pushLevel(1'b0, 5);
      for (int p = 0; p < 20; p++) begin
        hi = $urandom_range(1, 30);
        lo = ($urandom_range(0, 7) == 0) ? $urandom_range(225, 270) : $urandom_range(1, 30);
        pushLevel(1'b1, hi);
        pushLevel(1'b0, lo);
      end
      pushLevel(1'b0, 300);
      playStream();
      checkCount++;
      if (obsQ.size() != expQ.size())
        $display("[TB] FAIL random%0d_count got %0d want %0d", round, obsQ.size(), expQ.size());
      else passCount++;
      for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
        checkCount++;
        if (obsQ[i] !== expQ[i])
          $display("[TB] FAIL random%0d_pub%0d got p=%0d h=%0d t=%b want p=%0d h=%0d t=%b",
                   round, i, obsQ[i].period, obsQ[i].high, obsQ[i].timeout,
                   expQ[i].period, expQ[i].high, expQ[i].timeout);
        else passCount++;
      end
    end
    checkCount++;
    if (strayTimeout != 0)
      $display("[TB] FAIL timeout_without_valid got %0d want 0", strayTimeout);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_held_high();
    test_high10();
    test_coincident();
    test_enable_gap();
    test_async_reset();
    test_random();
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
